// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the manager FSM state type.
//   HTRANS_* : transfer type codes (IDLE, BUSY, NONSEQ, SEQ)
//   HSIZE_*  : transfer size codes (only BYTE is used by the manager)
//   HBURST_* : burst type codes (only SINGLE is used by the manager)
//   HRESP_*  : subordinate response codes (OKAY, ERROR)
//   state_e  : manager FSM state (ST_OKAY, ST_ERR)
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
    typedef enum logic {ST_OKAY, ST_ERR} state_e;
endpackage

// File: rtl/ahb_manager.sv
// ahb_manager: single-transfer AHB-Lite manager with a pipelined address slot and data slot.
//   hclk, hreset_n               : bus clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata : command request channel (valid/ready handshake)
//   rsp_valid/rdata/err          : one-cycle completion pulse, in acceptance order
//   haddr/htrans/hwrite/hsize/hburst/hwdata : registered AHB-Lite manager outputs
//   hready/hresp/hrdata          : subordinate response
module ahb_manager
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              hclk,
    input  logic              hreset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata
);
    state_e              state_q, state_d;
    // address slot
    logic                a_vld_q, a_vld_d;
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic                hwrite_q, hwrite_d;
    logic [DATA_W-1:0]   a_wdata_q, a_wdata_d;
    logic [1:0]          htrans_q, htrans_d;
    // data slot
    logic                d_vld_q, d_vld_d;
    logic                d_write_q, d_write_d;
    logic [DATA_W-1:0]   hwdata_q, hwdata_d;
    // response
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                accept;

    // Reset is folded in so cmd_ready drops the moment hreset_n is asserted.
    assign cmd_ready = hreset_n && state_q == ST_OKAY && (!a_vld_q || (hready && !hresp));
    assign accept    = cmd_valid && cmd_ready;

    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign hwrite    = hwrite_q;
    assign hwdata    = hwdata_q;
    assign hsize     = HSIZE_BYTE;
    assign hburst    = HBURST_SINGLE;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        a_vld_d     = a_vld_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        a_wdata_d   = a_wdata_q;
        d_vld_d     = d_vld_q;
        d_write_d   = d_write_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (state_q == ST_ERR) begin
            // Second ERROR cycle: the erroring transfer ends; the address slot was
            // never really issued (htrans IDLE) so it stays put for re-issue.
            if (hready) begin
                state_d     = ST_OKAY;
                d_vld_d     = 1'b0;
                rsp_valid_d = d_vld_q;
                rsp_err_d   = d_vld_q;
            end
        end else begin
            if (hready) begin
                // hresp high with hready high is a protocol error, still ends the transfer.
                rsp_valid_d = d_vld_q;
                rsp_err_d   = d_vld_q && hresp;
                rsp_rdata_d = (d_vld_q && !d_write_q && !hresp) ? hrdata : '0;
                d_vld_d     = a_vld_q;
                d_write_d   = hwrite_q;
                hwdata_d    = a_vld_q ? a_wdata_q : hwdata_q;
                a_vld_d     = 1'b0;
            end else if (hresp) begin
                state_d = ST_ERR;
            end
            if (accept) begin
                a_vld_d   = 1'b1;
                haddr_d   = cmd_addr;
                hwrite_d  = cmd_write;
                a_wdata_d = cmd_wdata;
            end
        end
        htrans_d = (a_vld_d && state_d == ST_OKAY) ? HTRANS_NONSEQ : HTRANS_IDLE;
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q     <= ST_OKAY;
            a_vld_q     <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            a_wdata_q   <= '0;
            htrans_q    <= HTRANS_IDLE;
            d_vld_q     <= 1'b0;
            d_write_q   <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_vld_q     <= a_vld_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            a_wdata_q   <= a_wdata_d;
            htrans_q    <= htrans_d;
            d_vld_q     <= d_vld_d;
            d_write_q   <= d_write_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
endmodule

// File: doc/ahb_manager.md
AHB_MANAGER -- requirements
Module: ahb_manager

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, HADDR width.
REQ-002 SHALL have parameter DATA_W, default 8, HWDATA/HRDATA width.
REQ-003 SHALL have port hclk, input, 1, bus clock; all state updates on its rising edge.
REQ-004 SHALL have port hreset_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, 1, command request.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid && cmd_ready at a clock edge.
REQ-007 SHALL have port cmd_write, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr, input, ADDR_W, transfer address.
REQ-009 SHALL have port cmd_wdata, input, DATA_W, write data.
REQ-010 SHALL have port rsp_valid, output, 1, one-cycle completion pulse; no backpressure.
REQ-011 SHALL have port rsp_rdata, output, DATA_W, read data; 0 for writes.
REQ-012 SHALL have port rsp_err, output, 1, transfer ended with ERROR.
REQ-013 SHALL have ports haddr (output, ADDR_W), htrans (output, 2), hwrite (output, 1), hsize (output, 3), hburst (output, 3), hwdata (output, DATA_W): AHB-Lite manager signals.
REQ-014 SHALL have ports hready (input, 1), hresp (input, 1), hrdata (input, DATA_W): subordinate response.

Function
REQ-015 All AHB outputs SHALL be driven from registers; hsize fixed BYTE (000), hburst fixed SINGLE (000).
REQ-016 SHALL hold at most one address-phase and one data-phase transfer (two outstanding).
REQ-017 Address phase: htrans = NONSEQ (10) while the address slot is occupied and not suppressed; otherwise IDLE (00), with haddr/hwrite holding their last values.
REQ-018 haddr, hwrite, htrans SHALL remain stable while hready = 0.
REQ-019 cmd_ready = address slot empty, OR (hready = 1 AND hresp = 0), in every state except ERR.
REQ-020 An accepted command SHALL appear on the bus in the cycle following acceptance.
REQ-021 At an edge with hready = 1, the address-phase transfer SHALL move to the data slot; hwdata SHALL present its cmd_wdata during the whole data phase.
REQ-022 At an edge with hready = 1 and hresp = 0 and an occupied data slot: rsp_valid = 1 in the next cycle; rsp_rdata = hrdata (reads) or 0 (writes); rsp_err = 0.
REQ-023 Zero-wait read latency: acceptance edge T; rsp_valid high in cycle T+3.
REQ-024 FSM states: OKAY, ERR. Transition OKAY->ERR at an edge with hresp = 1 and hready = 0 (first ERROR cycle). Transition ERR->OKAY at the next edge with hready = 1.
REQ-025 In ERR, htrans SHALL be IDLE and the address-slot command SHALL be retained, not dropped; cmd_ready = 0.
REQ-026 On leaving ERR: the erroring transfer completes with rsp_valid = 1, rsp_err = 1, rsp_rdata = 0. Any retained command is re-issued as NONSEQ in the next cycle, so responses stay in acceptance order.
REQ-027 hresp = 1 with hready = 1 while in OKAY SHALL be treated as a protocol error: the transfer completes with rsp_err = 1.
REQ-028 Back-to-back commands with hready = 1 continuously SHALL sustain one transfer per cycle.
REQ-029 rsp_valid, rsp_rdata and rsp_err SHALL be 0 in any cycle without a completion.

Reset
REQ-030 Asserting hreset_n low SHALL immediately force: htrans = IDLE, haddr = 0, hwrite = 0, hwdata = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, cmd_ready = 0, state = OKAY, both slots empty.
REQ-031 Reset mid-transfer SHALL discard all outstanding transfers without emitting responses.
REQ-032 cmd_ready SHALL go to 1 in the first cycle after hreset_n deasserts.

Structure
REQ-033 Shared package ahb_pkg SHALL define HTRANS (IDLE, BUSY, NONSEQ, SEQ), HSIZE, HBURST and HRESP (OKAY, ERROR) constants, plus the FSM state enum.
REQ-034 Single module, no sub-module; the two slots are explicit register groups.

Verification
REQ-035 Read 0x10, hready = 1, hrdata = 0xA5 in the data phase -> htrans = NONSEQ and haddr = 0x10 for one cycle; rsp_valid with rsp_rdata = 0xA5, rsp_err = 0 at T+3.
REQ-036 Write 0x22 <- 0x5C with hready held low for 2 data-phase cycles -> hwdata = 0x5C held for 3 cycles; a single rsp_valid with rsp_rdata = 0.
REQ-037 Back-to-back reads of 0x01, 0x02, 0x03, zero-wait -> NONSEQ on 3 consecutive cycles; 3 consecutive rsp_valid pulses in order.
REQ-038 Write 0x30 gets an ERROR response while read 0x31 is in its address phase -> htrans = IDLE in the second ERROR cycle; write returns rsp_err = 1; read 0x31 re-issued and returns rsp_err = 0.
REQ-039 Reset asserted while hready = 0 mid-data-phase -> outputs at reset values at once; no rsp_valid after release.
